imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences the byte-addressed instruction memory (little-endian, 4 bytes/instr). Owns the PC.
//  Shares the memory between a program-loader write port (IDLE/LOAD) and the fetch read path (RUN).
//  In RUN it drives pc_out to the memory and issues fetch_valid/flush to IF_ID.
//  Applies stall and branch/jump redirects and traps illegal fetch addresses.
// PARAMETERS
//  MEM_BYTES  48   instruction memory size in bytes; multiple of 4
//  RESET_PC   0    PC loaded on go; word-aligned, < MEM_BYTES
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   async active-low reset
//  load_valid      in   1   loader presents a word; legal only in IDLE/LOAD
//  load_addr       in   32  byte address of the loader word
//  load_data       in   32  loader word; byte0 = [7:0] goes to addr
//  load_ready      out  1   word accepted this cycle
//  load_done       in   1   loader finished; LOAD -> IDLE
//  go              in   1   start execution at RESET_PC
//  stall           in   1   hazard unit: hold PC
//  redirect_valid  in   1   taken branch/jump from EX
//  redirect_pc     in   32  redirect target byte address
//  mem_we          out  1   write strobe to instruction memory
//  mem_waddr       out  32  write byte address (word-aligned)
//  mem_wdata       out  32  write word
//  pc_out          out  32  fetch address to instruction memory
//  fetch_valid     out  1   instruction at pc_out is valid for IF_ID
//  flush           out  1   kill the younger instructions in IF_ID/ID_EX
//  fault           out  1   sticky: illegal fetch/load address
//  state_o         out  2   00 IDLE, 01 LOAD, 10 RUN, 11 FAULT
// BEHAVIOUR
//  Reset (async): state IDLE; pc_out=RESET_PC; fetch_valid, flush, fault, mem_we and load_ready = 0.
//  IDLE: load_valid -> LOAD (that word is accepted in LOAD). go -> RUN, pc=RESET_PC, fetch_valid=1 next cycle.
//    If load_valid and go are both high, load wins.
//  LOAD: load_ready = load_valid, combinational.
//    Accepted word: mem_we=1, mem_waddr=load_addr, mem_wdata=load_data in the same cycle.
//    Misaligned word or load_addr > MEM_BYTES-4: no write -> FAULT.
//    load_done (with no load_valid) -> IDLE next cycle. go is ignored in LOAD.
//    fetch_valid=0 throughout.
//  RUN: priority each cycle is redirect > stall > increment.
//    redirect: pc <= redirect_pc, and flush=1 for exactly the next cycle.
//      This applies even if stall is high, and fetch_valid stays 1.
//    stall: pc is held, fetch_valid stays 1, flush=0.
//    else: pc <= pc+4, 32-bit unsigned.
//  Fault checks in RUN:
//    Next pc misaligned (pc[1:0]!=0) or > MEM_BYTES-4 (including sequential fall-off and redirect) -> FAULT.
//    pc_out is not updated to the bad value. The fault check is registered.
//  FAULT: fault=1, fetch_valid=0, mem_we=0, pc_out frozen. Exit only via rst_n.
//  mem_we is never 1 in RUN or FAULT. pc_out is a register output with 0-cycle combinational read of the memory.
//  Redirect latency: redirect_valid at edge N -> pc_out=redirect_pc after edge N, flush high in cycle N+1.
//  Reset mid-LOAD or mid-RUN aborts immediately. Memory contents already written are retained.
// TESTING
//  1. Reset, go -> pc_out 0,4,8,...,44; the next increment (48) -> FAULT, fault=1, pc_out stays 44, fetch_valid=0.
//  2. RUN at pc=32, redirect_valid=1, redirect_pc=44 -> pc_out=44 next cycle, flush pulses 1 cycle.
//     At pc=40, redirect_pc=36 -> pc_out=36.
//  3. stall held 3 cycles at pc=12 -> pc_out=12 for 3 cycles, then 16.
//     stall+redirect(24) in the same cycle -> pc_out=24 and flush=1.
//  4. IDLE, load 12 words addr 0..44 back-to-back with load_done -> 12 mem_we pulses with matching addr/data.
//     Then go -> first fetch_valid at pc_out=0, state_o=10.
//  5. LOAD with load_addr=6 or 48 -> no mem_we, state_o=11, load_ready=0 afterwards.
//     redirect_pc=0x22 in RUN -> FAULT.
//  6. Assert rst_n low mid-RUN (pc=20) and mid-LOAD -> all outputs return to reset values asynchronously, state_o=00.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and loader/fetch sequencer for the instruction memory
module imem_fetch_ctrl #(
    parameter int          MEM_BYTES = 48,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        load_done,
    input  logic        go,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc_out,
    output logic        fetch_valid,
    output logic        flush,
    output logic        fault,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, FAULT = 2'b11} state_t;

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, target;
    logic        flush_nx, load_ok, target_ok;

    assign load_ok   = (load_addr[1:0] == 2'b00) && (load_addr <= LAST_PC);
    assign target    = redirect_valid ? redirect_pc : (stall ? pc : pc + 32'd4);
    assign target_ok = (target[1:0] == 2'b00) && (target <= LAST_PC);

    // State, PC and the one-cycle flush pulse; a bad next PC never reaches pc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            flush <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            flush <= flush_nx;
        end
    end

    // Next state: loader words win over go in IDLE; RUN takes redirect > stall > increment
    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        flush_nx   = 1'b0;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nx = LOAD;
                end else if (go) begin
                    state_nx = RUN;
                    pc_nx    = RESET_PC;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    load_ready = load_ok;
                    state_nx   = load_ok ? LOAD : FAULT;
                end else if (load_done) begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (target_ok) begin
                    pc_nx    = target;
                    flush_nx = redirect_valid;
                end else begin
                    state_nx = FAULT;
                end
            end
            FAULT: ;
        endcase
    end

    assign mem_we      = load_ready;
    assign mem_waddr   = load_addr;
    assign mem_wdata   = load_data;
    assign pc_out      = pc;
    assign fetch_valid = (state == RUN);
    assign fault       = (state == FAULT);
    assign state_o     = state;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and random checks of the fetch controller against a behavioural model
module tb_imem_fetch_ctrl;
    localparam int          MEM_BYTES = 48;
    localparam logic [31:0] RESET_PC  = 32'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0, load_done = 1'b0, go = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0, redirect_pc = '0;
    logic        load_ready, mem_we, fetch_valid, flush, fault;
    logic [31:0] mem_waddr, mem_wdata, pc_out;
    logic [1:0]  state_o;

    int checks = 0;
    int failures = 0;
    int we_seen = 0;

    int          mst = 0;
    logic [31:0] mpc = RESET_PC;
    logic        mflush = 1'b0;
    logic        exp_ready;

    imem_fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .go(go),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .pc_out(pc_out), .fetch_valid(fetch_valid), .flush(flush),
        .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // An address can hold an instruction word if it is word-aligned and the whole word fits
    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) + 4 <= longint'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] wanted_pc();
        if (redirect_valid) return redirect_pc;
        if (stall) return mpc;
        return mpc + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 loading, 2 running, 3 trapped
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst    <= 0;
            mpc    <= RESET_PC;
            mflush <= 1'b0;
        end else begin
            mflush <= 1'b0;
            if (mst == 0) begin
                if (load_valid) mst <= 1;
                else if (go) begin
                    mst <= 2;
                    mpc <= RESET_PC;
                end
            end else if (mst == 1) begin
                if (load_valid && !legal(load_addr)) mst <= 3;
                else if (!load_valid && load_done) mst <= 0;
            end else if (mst == 2) begin
                if (legal(wanted_pc())) begin
                    mpc    <= wanted_pc();
                    mflush <= redirect_valid;
                end else mst <= 3;
            end
        end
    end

    // Compare all outputs against the model every cycle
    always @(negedge clk) begin
        exp_ready = (mst == 1) && load_valid && legal(load_addr);
        chk("state_o", 32'(state_o), 32'(mst));
        chk("pc_out", pc_out, mpc);
        chk("fetch_valid", 32'(fetch_valid), 32'(mst == 2));
        chk("fault", 32'(fault), 32'(mst == 3));
        chk("flush", 32'(flush), 32'(mflush));
        chk("load_ready", 32'(load_ready), 32'(exp_ready));
        chk("mem_we", 32'(mem_we), 32'(exp_ready));
        if (exp_ready) begin
            chk("mem_waddr", mem_waddr, load_addr);
            chk("mem_wdata", mem_wdata, load_data);
        end
        if (mem_we) we_seen++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic assert_rst();
        {load_valid, load_done, go, stall, redirect_valid} = '0;
        load_addr = '0;
        load_data = '0;
        redirect_pc = '0;
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_run();
        assert_rst();
        release_rst();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_pc"}, pc_out, 32'd0);
        chk({tag, "_fv"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_ready"}, 32'(load_ready), 32'd0);
    endtask

    initial begin
        int base;
        assert_rst();
        chk_reset_outputs("rst");
        release_rst();

        start_run();
        chk("t1_state", 32'(state_o), 32'h2);
        for (int i = 0; i < 12; i++) begin
            chk("t1_pc", pc_out, 32'(4 * i));
            tick();
        end
        chk("t1_fstate", 32'(state_o), 32'h3);
        chk("t1_fpc", pc_out, 32'd44);
        chk("t1_ffault", 32'(fault), 32'd1);
        chk("t1_ffv", 32'(fetch_valid), 32'd0);

        start_run();
        tick(8);
        chk("t2_pc32", pc_out, 32'd32);
        redirect_valid = 1'b1;
        redirect_pc = 32'd44;
        tick();
        redirect_valid = 1'b0;
        chk("t2_pc44", pc_out, 32'd44);
        chk("t2_flush1", 32'(flush), 32'd1);
        tick();
        chk("t2_flush0", 32'(flush), 32'd0);
        start_run();
        tick(10);
        redirect_valid = 1'b1;
        redirect_pc = 32'd36;
        tick();
        redirect_valid = 1'b0;
        chk("t2_pc36", pc_out, 32'd36);
        chk("t2_fv", 32'(fetch_valid), 32'd1);
        tick();
        chk("t2_pc40", pc_out, 32'd40);

        start_run();
        tick(3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_pc", pc_out, 32'd12);
            chk("t3_stall_fv", 32'(fetch_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("t3_pc16", pc_out, 32'd16);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd24;
        tick();
        {stall, redirect_valid} = '0;
        chk("t3_pc24", pc_out, 32'd24);
        chk("t3_flush", 32'(flush), 32'd1);

        assert_rst();
        release_rst();
        base = we_seen;
        load_valid = 1'b1;
        tick();
        chk("t4_state", 32'(state_o), 32'h1);
        for (int i = 0; i < 12; i++) begin
            load_addr = 32'(4 * i);
            load_data = 32'h1000_0000 + 32'(i * 3);
            #1;
            chk("t4_we", 32'(mem_we), 32'd1);
            chk("t4_waddr", mem_waddr, 32'(4 * i));
            chk("t4_wdata", mem_wdata, 32'h1000_0000 + 32'(i * 3));
            tick();
        end
        load_valid = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("t4_writes", 32'(we_seen - base), 32'd12);
        chk("t4_idle", 32'(state_o), 32'h0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t4_run", 32'(state_o), 32'h2);
        chk("t4_pc", pc_out, 32'd0);
        chk("t4_fv", 32'(fetch_valid), 32'd1);

        for (int k = 0; k < 2; k++) begin
            assert_rst();
            release_rst();
            load_valid = 1'b1;
            load_addr = (k == 0) ? 32'd6 : 32'd48;
            tick();
            #1;
            chk("t5_no_we", 32'(mem_we), 32'd0);
            tick();
            chk("t5_state", 32'(state_o), 32'h3);
            chk("t5_ready", 32'(load_ready), 32'd0);
        end
        start_run();
        redirect_valid = 1'b1;
        redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        chk("t5_rstate", 32'(state_o), 32'h3);
        chk("t5_rpc", pc_out, 32'd0);

        start_run();
        tick(5);
        chk("t6_pc20", pc_out, 32'd20);
        #2;
        assert_rst();
        chk_reset_outputs("t6run");
        release_rst();
        load_valid = 1'b1;
        load_addr = 32'd8;
        tick();
        #2;
        assert_rst();
        chk_reset_outputs("t6load");
        release_rst();

        for (int c = 0; c < 3000; c++) begin
            if ((mst == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                assert_rst();
                release_rst();
            end else begin
                go = ($urandom_range(0, 5) == 0);
                load_valid = ($urandom_range(0, 2) == 0);
                load_addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 63)) : 32'(4 * $urandom_range(0, 11));
                load_data = $urandom;
                load_done = ($urandom_range(0, 3) == 0);
                stall = ($urandom_range(0, 3) == 0);
                redirect_valid = ($urandom_range(0, 5) == 0);
                redirect_pc = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 63)) : 32'(4 * $urandom_range(0, 11));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
